i2s_transmitter: RTL and testbench



---
 rtl/i2s_transmitter.sv | 128 ++++++++++++
 tb/tb_i2s_transmitter.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// I2S transmitter: serializes buffered stereo PCM pairs onto sd_out, MSB-first,
// one sck after each ws edge. Ports: clk_in, rst_in, sck, ws, left_in,
// right_in, sample_valid_in, sample_ready_out, sd_out, underrun_out.
module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    sck,
  input  logic                    ws,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic                    sd_out,
  output logic                    underrun_out
);

  localparam int CW = $clog2(SLOT_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SLOT_WIDTH);

  typedef enum logic {
    SYNC,
    ACTIVE
  } state_t;

  state_t                  state;
  logic                    sck_prev;
  logic                    ws_last;
  logic                    buf_full;
  logic                    chan;
  logic [CW-1:0]           bit_cnt;
  logic [SAMPLE_WIDTH-1:0] buf_left;
  logic [SAMPLE_WIDTH-1:0] buf_right;
  logic [SAMPLE_WIDTH-1:0] frame_left;
  logic [SAMPLE_WIDTH-1:0] frame_right;

  logic                    fall;
  logic                    ws_edge;
  logic                    frame_start;
  logic                    accept;
  logic [SAMPLE_WIDTH-1:0] chan_word;
  logic [SAMPLE_WIDTH-1:0] shifted;
  logic                    slot_bit;

  assign fall             = !sck && sck_prev;
  assign ws_edge          = fall && (ws != ws_last);
  assign frame_start      = ws_edge && ws_last && !ws;
  assign accept           = sample_valid_in && !buf_full;
  assign sample_ready_out = !buf_full;
  assign chan_word        = chan ? frame_right : frame_left;

  // Shifting left by the bit count puts the next bit at the MSB and
  // naturally yields 0 once the count runs past the sample width.
  always_comb begin
    shifted  = chan_word << bit_cnt;
    slot_bit = shifted[SAMPLE_WIDTH-1];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= SYNC;
      sck_prev     <= 1'b0;
      ws_last      <= 1'b0;
      buf_full     <= 1'b0;
      chan         <= 1'b0;
      bit_cnt      <= '0;
      buf_left     <= '0;
      buf_right    <= '0;
      frame_left   <= '0;
      frame_right  <= '0;
      sd_out       <= 1'b0;
      underrun_out <= 1'b0;
    end else begin
      sck_prev     <= sck;
      underrun_out <= 1'b0;

      if (fall) begin
        ws_last <= ws;
      end

      if (accept) begin
        buf_left  <= left_in;
        buf_right <= right_in;
        buf_full  <= 1'b1;
      end

      // A pair accepted in this same cycle is kept for the next frame.
      if (frame_start) begin
        if (buf_full) begin
          frame_left  <= buf_left;
          frame_right <= buf_right;
          buf_full    <= 1'b0;
        end else begin
          frame_left   <= '0;
          frame_right  <= '0;
          underrun_out <= 1'b1;
        end
      end

      unique case (state)
        SYNC: begin
          sd_out <= 1'b0;
          if (frame_start) begin
            state   <= ACTIVE;
            chan    <= 1'b0;
            bit_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (fall) begin
            // On a ws edge this still emits the old word's last slot bit.
            sd_out <= slot_bit;
            if (ws_edge) begin
              bit_cnt <= '0;
              chan    <= ws;
            end else if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Testbench for i2s_transmitter: drives sck/ws like a controller, decodes
// sd_out like an I2S receiver, and compares against a frame-level model.
module tb_i2s_transmitter;

  typedef struct packed {
    logic        ch;
    logic [15:0] w;
    logic        pad_ok;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        ws = 1'b1;
  logic [15:0] left = '0;
  logic [15:0] right = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        sd;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  i2s_transmitter #(
    .SAMPLE_WIDTH(16),
    .SLOT_WIDTH  (32)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .sck             (sck),
    .ws              (ws),
    .left_in         (left),
    .right_in        (right),
    .sample_valid_in (valid),
    .sample_ready_out(ready),
    .sd_out          (sd),
    .underrun_out    (underrun)
  );

  always #5 clk = ~clk;

  // sck/ws source: 64 sck periods per frame, ws flips on sck falling.
  int  half = 16;
  int  div_cnt = 0;
  int  bit_idx = 40;
  int  frame_cnt = 0;
  longint cyc = 0;
  longint fs_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_cnt >= half - 1) begin
      div_cnt <= 0;
      sck <= ~sck;
      if (sck) begin
        bit_idx <= (bit_idx + 1) % 64;
        ws <= (((bit_idx + 1) % 64) >= 32);
        if (bit_idx == 63) begin
          frame_cnt <= frame_cnt + 1;
          fs_cyc <= cyc;
        end
      end
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  // Receiver: samples sd on sck rising; the bit after a ws change is MSB.
  slot_t       rx_q[$];
  slot_t       exp_q[$];
  int          ur_count = 0;
  int          ur_long = 0;
  logic        ur_prev = 1'b0;
  logic        m_sck = 1'b0;
  logic        m_ws = 1'b0;
  int          m_n = 0;
  logic [31:0] m_bits = '0;

  always @(negedge clk) begin
    slot_t s;
    if (underrun) begin
      ur_count++;
      if (ur_prev) ur_long++;
    end
    ur_prev = underrun;
    if (sck && !m_sck) begin
      if (ws != m_ws) begin
        if (m_n == 32) begin
          s.ch = m_ws;
          for (int j = 0; j < 16; j++) s.w[15-j] = m_bits[1+j];
          s.pad_ok = !m_bits[0] && (m_bits[31:17] == '0);
          rx_q.push_back(s);
        end
        m_n = 0;
        m_bits = '0;
        m_ws = ws;
      end
      if (m_n < 32) m_bits[m_n] = sd;
      m_n++;
    end
    m_sck = sck;
  end

  logic [15:0] stim_l[$];
  logic [15:0] stim_r[$];
  bit          stim_p[$];
  int          exp_ur;
  int          ur_seen;

  task automatic wait_frame_cnt(input int target);
    int g = 0;
    while (frame_cnt < target && g < 5000) begin
      @(posedge clk);
      g++;
    end
    if (frame_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL frame_wait got %0d want %0d", frame_cnt, target);
    end
  endtask

  task automatic wait_fs();
    wait_frame_cnt(frame_cnt + 1);
  endtask

  task automatic settle();
    repeat (8 * half) @(posedge clk);
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    int g = 0;
    @(negedge clk);
    valid = 1'b1;
    left = l;
    right = r;
    while (!ready && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout got ready=%0b want 1", ready);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Model: each frame start takes the pair pushed during the previous
  // frame, or sends zeros with one underrun pulse if nothing was pushed.
  task automatic drive_frames();
    int f0;
    int ur0;
    int n;
    slot_t z0;
    slot_t z1;
    n = stim_l.size();
    z0 = '{ch: 1'b0, w: 16'h0, pad_ok: 1'b1};
    z1 = '{ch: 1'b1, w: 16'h0, pad_ok: 1'b1};
    wait_fs();
    settle();
    rx_q.delete();
    exp_q.delete();
    f0 = frame_cnt;
    ur0 = ur_count;
    exp_q.push_back(z0);
    exp_q.push_back(z1);
    exp_ur = 1;
    for (int k = 0; k < n; k++) begin
      if (stim_p[k]) begin
        push_pair(stim_l[k], stim_r[k]);
        exp_q.push_back('{ch: 1'b0, w: stim_l[k], pad_ok: 1'b1});
        exp_q.push_back('{ch: 1'b1, w: stim_r[k], pad_ok: 1'b1});
      end else begin
        exp_q.push_back(z0);
        exp_q.push_back(z1);
        exp_ur++;
      end
      wait_frame_cnt(f0 + k + 1);
    end
    wait_frame_cnt(f0 + n + 1);
    settle();
    ur_seen = ur_count - ur0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (sd !== 1'b0) begin
      errors++;
      $display("FAIL reset_sd got %b want 0", sd);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_underrun got %b want 0", underrun);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", ready);
    end
  endtask

  task automatic test_startup_sync();
    int f0;
    int ur0;
    int g = 0;
    bit saw_sd = 0;
    bit saw_ur = 0;
    rst = 1'b0;
    f0 = frame_cnt;
    ur0 = ur_count;
    while (frame_cnt == f0 && g < 5000) begin
      @(negedge clk);
      if (sd) saw_sd = 1;
      if (underrun) saw_ur = 1;
      g++;
    end
    checks++;
    if (saw_sd || saw_ur) begin
      errors++;
      $display("FAIL sync_quiet got sd=%0b ur=%0b want 0 0",
               saw_sd, saw_ur);
    end
    settle();
    checks++;
    if (ur_count - ur0 != 1 || ur_long != 0) begin
      errors++;
      $display("FAIL sync_underrun got %0d/%0d want 1/0",
               ur_count - ur0, ur_long);
    end
  endtask

  task automatic test_nominal();
    half = 16;
    stim_l = '{16'hBEEF};
    stim_r = '{16'h1234};
    stim_p = '{1'b1};
    drive_frames();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL nom_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL nom_word[%0d] got ch%0b %h pad%0b want ch%0b %h",
                 i, rx_q[i].ch, rx_q[i].w, rx_q[i].pad_ok,
                 exp_q[i].ch, exp_q[i].w);
      end
    end
    checks++;
    if (ur_seen != exp_ur) begin
      errors++;
      $display("FAIL nom_underrun got %0d want %0d", ur_seen, exp_ur);
    end
  endtask

  task automatic test_backpressure();
    int f0;
    int ur0;
    int g = 0;
    slot_t e[$];
    half = 4;
    wait_fs();
    settle();
    rx_q.delete();
    f0 = frame_cnt;
    ur0 = ur_count;
    @(negedge clk);
    valid = 1'b1;
    left = 16'h0001;
    right = 16'h8000;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_drop got %b want 0", ready);
    end
    left = 16'h7FFF;
    right = 16'hFFFF;
    while (!ready && g < 5000) begin
      @(negedge clk);
      g++;
    end
    // Generator edge, then the DUT's frame-start cycle, then ready.
    checks++;
    if (!ready || cyc != fs_cyc + 2) begin
      errors++;
      $display("FAIL bp_reassert got %0d want %0d", cyc, fs_cyc + 2);
    end
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second got %b want 0", ready);
    end
    wait_frame_cnt(f0 + 3);
    settle();
    e = '{'{1'b0, 16'h0000, 1'b1}, '{1'b1, 16'h0000, 1'b1},
          '{1'b0, 16'h0001, 1'b1}, '{1'b1, 16'h8000, 1'b1},
          '{1'b0, 16'h7FFF, 1'b1}, '{1'b1, 16'hFFFF, 1'b1}};
    checks++;
    if (rx_q.size() != e.size()) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d", rx_q.size(), e.size());
    end
    for (int i = 0; i < e.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== e[i]) begin
        errors++;
        $display("FAIL bp_word[%0d] got ch%0b %h want ch%0b %h",
                 i, rx_q[i].ch, rx_q[i].w, e[i].ch, e[i].w);
      end
    end
    checks++;
    if (ur_count - ur0 != 1) begin
      errors++;
      $display("FAIL bp_underrun got %0d want 1", ur_count - ur0);
    end
  endtask

  task automatic test_underrun();
    half = 4;
    stim_l = '{16'h0, 16'h0, 16'h0};
    stim_r = '{16'h0, 16'h0, 16'h0};
    stim_p = '{1'b0, 1'b0, 1'b0};
    drive_frames();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ur_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ur_word[%0d] got ch%0b %h want ch%0b %h",
                 i, rx_q[i].ch, rx_q[i].w, exp_q[i].ch, exp_q[i].w);
      end
    end
    checks++;
    if (ur_seen != exp_ur || ur_long != 0) begin
      errors++;
      $display("FAIL ur_pulses got %0d/%0d want %0d/0",
               ur_seen, ur_long, exp_ur);
    end
  endtask

  task automatic test_reset_midword();
    int f0;
    int ur0;
    int g = 0;
    bit saw = 0;
    half = 4;
    wait_fs();
    settle();
    push_pair(16'hBEEF, 16'h1234);
    f0 = frame_cnt;
    wait_frame_cnt(f0 + 1);
    while (bit_idx != 9 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    checks++;
    if (sd !== 1'b1) begin
      errors++;
      $display("FAIL rst_bit7 got %b want 1", sd);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (sd !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got sd=%b rdy=%b want 0 1", sd, ready);
    end
    f0 = frame_cnt;
    ur0 = ur_count;
    g = 0;
    while (frame_cnt == f0 && g < 5000) begin
      @(negedge clk);
      if (sd || underrun) saw = 1;
      g++;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL rst_quiet got activity=1 want 0");
    end
    settle();
    checks++;
    if (ur_count - ur0 != 1) begin
      errors++;
      $display("FAIL rst_underrun got %0d want 1", ur_count - ur0);
    end
    rx_q.delete();
    wait_frame_cnt(frame_cnt + 1);
    settle();
    checks++;
    if (rx_q.size() < 2 || rx_q[0] !== slot_t'{1'b0, 16'h0, 1'b1}
        || rx_q[1] !== slot_t'{1'b1, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL rst_zero got n=%0d want 2 zero words", rx_q.size());
    end
  endtask

  task automatic test_random();
    half = 2;
    stim_l.delete();
    stim_r.delete();
    stim_p.delete();
    for (int k = 0; k < 20; k++) begin
      stim_l.push_back(16'($urandom));
      stim_r.push_back(16'($urandom));
      stim_p.push_back(($urandom % 4) != 0);
    end
    drive_frames();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rnd_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rnd_word[%0d] got ch%0b %h want ch%0b %h",
                 i, rx_q[i].ch, rx_q[i].w, exp_q[i].ch, exp_q[i].w);
      end
    end
    checks++;
    if (ur_seen != exp_ur || ur_long != 0) begin
      errors++;
      $display("FAIL rnd_underrun got %0d want %0d", ur_seen, exp_ur);
    end
  endtask

  task automatic test_sine();
    half = 2;
    stim_l.delete();
    stim_r.delete();
    stim_p.delete();
    for (int k = 0; k < 64; k++) begin
      stim_l.push_back(16'(int'(48879.0 * $sin(real'(k) / 5.0))));
      stim_r.push_back(16'(int'(48879.0 * $cos(real'(k) / 5.0))));
      stim_p.push_back(1'b1);
    end
    drive_frames();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sine_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sine_word[%0d] got ch%0b %h want ch%0b %h",
                 i, rx_q[i].ch, rx_q[i].w, exp_q[i].ch, exp_q[i].w);
      end
    end
    checks++;
    if (ur_seen != exp_ur) begin
      errors++;
      $display("FAIL sine_underrun got %0d want %0d", ur_seen, exp_ur);
    end
  endtask

  initial begin
    test_reset();
    test_startup_sync();
    test_nominal();
    test_backpressure();
    test_underrun();
    test_reset_midword();
    test_random();
    test_sine();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
